serial_add_sub: RTL and testbench

- Multi-cycle, parametrised adder/subtractor built around a DIGIT-bit full-adder slice and a registered carry.
- Processes WIDTH-bit operands DIGIT bits per cycle, LSB digit first.
- Start/busy/done handshake; reports sum, carry-out and signed overflow.
- Serves as the area-lean arithmetic unit for datapaths that cannot afford a full-width combinational adder.

---
 rtl/serial_add_sub_if.sv | 26 ++
 rtl/serial_add_sub.sv | 134 +++++++++++++
 tb/tb_serial_add_sub.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: start/busy/done handshake and operand/result bus
// for the digit-serial adder/subtractor.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, sum, carry, overflow
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, sum, carry, overflow
  );
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: WIDTH-bit add/sub, DIGIT bits per cycle, LSB first.
// Registered carry between digits; sum/carry/overflow updated on last digit.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_sub_if.slave    bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;

  logic [DIGIT-1:0] w_s;
  logic             w_cy;
  logic             w_cmsb;
  logic             w_cout;
  logic             w_last;
  logic             w_load;
  logic             w_run;
  logic [WIDTH-1:0] w_full;

  assign w_run  = (r_state == S_RUN);
  assign w_load = bus.start && !w_run;
  assign w_last = (r_cnt == CW'(N - 1));

  // DIGIT-bit ripple slice; also exposes the carry into its top bit
  always_comb begin
    w_s    = '0;
    w_cy   = r_c;
    w_cmsb = r_c;
    for (int i = 0; i < DIGIT; i++) begin
      w_cmsb = w_cy;
      w_s[i] = r_a[i] ^ r_b[i] ^ w_cy;
      w_cy   = (r_a[i] & r_b[i]) | (w_cy & (r_a[i] ^ r_b[i]));
    end
    w_cout = w_cy;
  end

  // Partial sum shifts in from the MSB end, so the final digit
  // completes the word without a separate shift step
  generate
    if (N > 1) begin : g_multi
      logic [WIDTH-DIGIT-1:0] r_acc;
      assign w_full = {w_s, r_acc};
      // Running partial-sum shift register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_acc <= '0;
        end else if (w_run) begin
          r_acc <= w_full[WIDTH-1:DIGIT];
        end
      end
    end else begin : g_single
      assign w_full = w_s;
    end
  endgenerate

  // State register plus registered busy/done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_RUN);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Next-state: DONE lasts one cycle and accepts a new start
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = bus.start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand load, per-digit shift and final result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a   <= bus.a;
      r_b   <= bus.mode ? ~bus.b : bus.b;
      r_c   <= bus.mode ? 1'b1 : bus.cin;
      r_cnt <= '0;
    end else if (w_run) begin
      r_a   <= r_a >> DIGIT;
      r_b   <= r_b >> DIGIT;
      r_c   <= w_cout;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum   <= w_full;
        r_carry <= w_cout;
        r_ovf   <= w_cmsb ^ w_cout;
      end
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.sum      = r_sum;
  assign bus.carry    = r_carry;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed and random checks of serial_add_sub
// in three WIDTH/DIGIT configurations with a result scoreboard.
module tb_serial_add_sub;
  localparam int W0 = 8;
  localparam int D0 = 1;
  localparam int W1 = 8;
  localparam int D1 = 4;
  localparam int W2 = 16;
  localparam int D2 = 2;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_asrt = 0;
  int   n_fail = 0;
  res_t q0[$];
  res_t q1[$];
  res_t q2[$];

  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(W0)) b0 ();
  serial_add_sub_if #(.WIDTH(W1)) b1 ();
  serial_add_sub_if #(.WIDTH(W2)) b2 ();

  serial_add_sub #(.WIDTH(W0), .DIGIT(D0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  serial_add_sub #(.WIDTH(W1), .DIGIT(D1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  serial_add_sub #(.WIDTH(W2), .DIGIT(D2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(int w, logic m, logic [15:0] a,
                                 logic [15:0] b, logic ci);
    logic [16:0] mask;
    logic [16:0] bb;
    logic [16:0] full;
    res_t r;
    mask = (17'd1 << w) - 17'd1;
    bb   = m ? (~{1'b0, b} & mask) : {1'b0, b};
    full = {1'b0, a} + bb + {16'd0, (m ? 1'b1 : ci)};
    r.s  = full[15:0] & mask[15:0];
    r.c  = full[w];
    r.o  = (a[w-1] == bb[w-1]) && (r.s[w-1] != a[w-1]);
    return r;
  endfunction

  always @(negedge clk) begin : mon0
    res_t e;
    if (b0.done) begin
      chk("u0_unexpected_done", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("u0_sum", 32'(b0.sum), 32'(e.s));
        chk("u0_carry", 32'(b0.carry), 32'(e.c));
        chk("u0_ovf", 32'(b0.overflow), 32'(e.o));
      end
    end
  end

  always @(negedge clk) begin : mon1
    res_t e;
    if (b1.done) begin
      chk("u1_unexpected_done", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("u1_sum", 32'(b1.sum), 32'(e.s));
        chk("u1_carry", 32'(b1.carry), 32'(e.c));
        chk("u1_ovf", 32'(b1.overflow), 32'(e.o));
      end
    end
  end

  always @(negedge clk) begin : mon2
    res_t e;
    if (b2.done) begin
      chk("u2_unexpected_done", 32'(q2.size() != 0), 1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        chk("u2_sum", 32'(b2.sum), 32'(e.s));
        chk("u2_carry", 32'(b2.carry), 32'(e.c));
        chk("u2_ovf", 32'(b2.overflow), 32'(e.o));
      end
    end
  end

  task automatic op0(input logic m, input logic [7:0] a,
                     input logic [7:0] b, input logic ci,
                     input res_t e, input bit now);
    if (!now) @(negedge clk);
    b0.mode  = m;
    b0.a     = a;
    b0.b     = b;
    b0.cin   = ci;
    b0.start = 1'b1;
    q0.push_back(e);
    @(posedge clk);
    #1 b0.start = 1'b0;
  endtask

  task automatic wait0(input bit glitch, input string tag);
    int nb;
    int dk;
    nb = 0;
    dk = 0;
    for (int k = 1; k <= 40 && dk == 0; k++) begin
      @(negedge clk);
      if (glitch) begin
        if (k == 3 || k == 5) begin
          b0.start = 1'b1;
          b0.a     = 8'($urandom);
          b0.b     = 8'($urandom);
          b0.mode  = ~b0.mode;
          b0.cin   = ~b0.cin;
        end else begin
          b0.start = 1'b0;
        end
      end
      if (b0.busy) nb++;
      if (b0.done) dk = k;
    end
    chk({tag, "_done_cycle"}, 32'(dk), 32'(W0 / D0 + 1));
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(W0 / D0));
  endtask

  initial begin
    int nd;
    int dk;
    res_t e;
    logic m;
    logic ci;
    logic [15:0] ra;
    logic [15:0] rb;
    if ((W0 % D0) != 0 || (W1 % D1) != 0 || (W2 % D2) != 0) begin
      $display("FAIL digit_param DIGIT must divide WIDTH");
      $fatal(1);
    end
    b0.start = 0; b0.mode = 0; b0.a = 0; b0.b = 0; b0.cin = 0;
    b1.start = 0; b1.mode = 0; b1.a = 0; b1.b = 0; b1.cin = 0;
    b2.start = 0; b2.mode = 0; b2.a = 0; b2.b = 0; b2.cin = 0;
    #12;
    chk("rst_busy", 32'(b0.busy), 0);
    chk("rst_done", 32'(b0.done), 0);
    chk("rst_sum", 32'(b0.sum), 0);
    chk("rst_carry", 32'(b0.carry), 0);
    chk("rst_ovf", 32'(b0.overflow), 0);
    @(negedge clk) rst_n = 1'b1;

    op0(0, 8'h5A, 8'h33, 0, '{16'h008D, 1'b0, 1'b1}, 0);
    wait0(0, "add5a33");
    op0(0, 8'hFF, 8'h01, 0, '{16'h0000, 1'b1, 1'b0}, 0);
    wait0(0, "addff01");
    op0(0, 8'h7F, 8'h00, 1, '{16'h0080, 1'b0, 1'b1}, 0);
    wait0(0, "add7f00c");
    op0(1, 8'h10, 8'h20, 1, '{16'h00F0, 1'b0, 1'b0}, 0);
    wait0(0, "sub1020");
    op0(1, 8'h80, 8'h01, 0, '{16'h007F, 1'b1, 1'b1}, 0);
    wait0(0, "sub8001");

    op0(0, 8'h12, 8'h34, 0, '{16'h0046, 1'b0, 1'b0}, 0);
    wait0(1, "ignore_start");
    op0(0, 8'hC3, 8'h3C, 0, '{16'h00FF, 1'b0, 1'b0}, 1);
    wait0(0, "back2back");

    op0(0, 8'h01, 8'h02, 0, model(8, 0, 16'h01, 16'h02, 0), 0);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(b0.busy), 0);
    chk("abort_done", 32'(b0.done), 0);
    chk("abort_sum", 32'(b0.sum), 0);
    chk("abort_carry", 32'(b0.carry), 0);
    chk("abort_ovf", 32'(b0.overflow), 0);
    void'(q0.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (b0.done) nd++;
    end
    chk("abort_no_done", 32'(nd), 0);
    op0(0, 8'h21, 8'h42, 0, '{16'h0063, 1'b0, 1'b0}, 0);
    wait0(0, "after_abort");

    @(negedge clk);
    b1.mode = 0; b1.a = 8'hF8; b1.b = 8'h08; b1.cin = 0;
    b1.start = 1'b1;
    q1.push_back('{16'h0000, 1'b1, 1'b0});
    @(posedge clk);
    #1 b1.start = 1'b0;
    dk = 0;
    for (int k = 1; k <= 20 && dk == 0; k++) begin
      @(negedge clk);
      if (b1.done) dk = k;
    end
    chk("d4_done_cycle", 32'(dk), 32'(W1 / D1 + 1));

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      m  = 1'($urandom);
      ci = 1'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 0) begin
        ra = 16'h8000;
        rb = 16'h0001;
        m  = 1'b1;
      end
      b2.mode = m; b2.a = ra; b2.b = rb; b2.cin = ci;
      b2.start = 1'b1;
      q2.push_back(model(W2, m, ra, rb, ci));
      @(posedge clk);
      #1 b2.start = 1'b0;
      dk = 0;
      for (int k = 1; k <= 20 && dk == 0; k++) begin
        @(negedge clk);
        if (b2.done) dk = k;
      end
      if (dk != W2 / D2 + 1)
        chk("sweep_done_cycle", 32'(dk), 32'(W2 / D2 + 1));
    end

    @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q2_drained", 32'(q2.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end
endmodule
